// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Format codes match the decode-side immediate extractor.
package instr_encoder_pkg;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  typedef logic [31:0] instr_t;

  // Fields captured by stage 1 and consumed by the packer.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
  } enc_fields_t;

  // True when v is a sign-extension of its low 'bits' bits.
  function automatic logic sign_fits(input logic [31:0] v, input int bits);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if ((k >= bits - 1) && (v[k] != v[bits-1])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with optional immediate range checker.
// Optional feature: IMM_RANGE_CHECK_EN (flags immediates that would be truncated).
module instr_pack
  import instr_encoder_pkg::*;
(
  input  enc_fields_t i_fields,
  output instr_t      o_instr,
  output logic        o_err
);

  instr_t w_word;
  logic   w_fmt_err;
  logic   w_range_err;

  // Scatter the immediate into its format-specific bit positions.
  always_comb begin
    w_word    = '0;
    w_fmt_err = 1'b0;
    case (i_fields.fmt)
      FMT_I: w_word = {i_fields.imm[11:0], i_fields.rs1, i_fields.funct3,
                       i_fields.rd, i_fields.opcode};
      FMT_S: w_word = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1,
                       i_fields.funct3, i_fields.imm[4:0], i_fields.opcode};
      FMT_B: w_word = {i_fields.imm[12], i_fields.imm[10:5], i_fields.rs2,
                       i_fields.rs1, i_fields.funct3, i_fields.imm[4:1],
                       i_fields.imm[11], i_fields.opcode};
      FMT_U: w_word = {i_fields.imm[31:12], i_fields.rd, i_fields.opcode};
      FMT_J: w_word = {i_fields.imm[20], i_fields.imm[10:1], i_fields.imm[11],
                       i_fields.imm[19:12], i_fields.rd, i_fields.opcode};
      default: w_fmt_err = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates whose significant bits do not fit the encoded field.
  always_comb begin
    w_range_err = 1'b0;
    case (i_fields.fmt)
      FMT_I, FMT_S: w_range_err = !sign_fits(i_fields.imm, 12);
      FMT_B:        w_range_err = !sign_fits(i_fields.imm, 13) | i_fields.imm[0];
      FMT_J:        w_range_err = !sign_fits(i_fields.imm, 21) | i_fields.imm[0];
      FMT_U:        w_range_err = |i_fields.imm[11:0];
      default:      w_range_err = 1'b0;
    endcase
  end
`else
  assign w_range_err = 1'b0;
`endif

  // Any error forces an all-zero word so a bad encoding is never executable.
  always_comb begin
    o_err   = w_fmt_err | w_range_err;
    o_instr = o_err ? '0 : w_word;
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with handoff counter.
// Optional feature: IMM_RANGE_CHECK_EN (range checking inside instr_pack).
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_format,
  input  logic [31:0] in_imm,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count
);

  logic        r_s1_valid;
  enc_fields_t r_s1_fields;
  logic        r_s2_valid;
  instr_t      r_s2_instr;
  logic        r_s2_err;
  logic [15:0] r_count;

  enc_fields_t w_in_fields;
  instr_t      w_pack_instr;
  logic        w_pack_err;
  logic        w_s2_adv;
  logic        w_handoff;
  logic        w_unused_funct7;

  // funct7 only matters for R-type, which this encoder does not produce.
  assign w_unused_funct7 = ^in_funct7;

  assign w_in_fields = '{fmt: in_format, imm: in_imm, opcode: in_opcode,
                         rd: in_rd, rs1: in_rs1, rs2: in_rs2, funct3: in_funct3};

  // Stage 2 can load when empty or when its word leaves this cycle; stage 1
  // drains into stage 2 under the same condition. Gating with rst_n keeps the
  // reset cycle free of accepts and handoffs.
  assign w_s2_adv  = !r_s2_valid | out_ready;
  assign in_ready  = rst_n & (!r_s1_valid | w_s2_adv);
  assign out_valid = rst_n & r_s2_valid;
  assign w_handoff = out_valid & out_ready;

  instr_pack u_pack (
    .i_fields (r_s1_fields),
    .o_instr  (w_pack_instr),
    .o_err    (w_pack_err)
  );

  // Stage 1: capture accepted input fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_fields <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_fields <= w_in_fields;
    end
  end

  // Stage 2: register the packed word; hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_pack_instr;
        r_s2_err   <= w_pack_err;
      end
    end
  end

  // Count handoffs; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) r_count <= '0;
    else if (w_handoff) r_count <= r_count + 16'd1;
  end

  assign out_instr = r_s2_instr;
  assign out_err   = r_s2_err;
  assign enc_count = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard testbench for instr_encoder (directed vectors).
// Expected values depend on IMM_RANGE_CHECK_EN.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_format;
  logic [31:0] in_imm;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_format (in_format),
    .in_imm    (in_imm),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  localparam int NVEC = 14;
  vec_t  vecs[NVEC];
  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    ntx = 0;
  logic [15:0] exp_count = 16'd0;
  bit    prev_stall = 1'b0;
  logic [31:0] prev_instr = '0;
  logic  prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [2:0] fmt, input logic [31:0] imm,
                              input logic [6:0] opc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] instr, input logic err);
    vec_t v;
    v.fmt = fmt; v.imm = imm; v.opc = opc; v.rd = rd; v.rs1 = rs1;
    v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.instr = instr; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: sample just before each rising edge; a handoff pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (prev_stall && out_valid) begin
      chk("stall_hold_instr", out_instr, prev_instr);
      chk("stall_hold_err", {31'd0, out_err}, {31'd0, prev_err});
    end
    prev_stall = out_valid && !out_ready;
    prev_instr = out_instr;
    prev_err   = out_err;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", out_instr);
      end else begin
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_err", {31'd0, out_err}, {31'd0, e.err});
        if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 32'd2);
        exp_count = exp_count + 16'd1;
        $display("tx %0d: instr=%h err=%0d count_before=%0d", ntx, out_instr, out_err, enc_count);
        ntx++;
      end
    end
  end

  task automatic drive(input vec_t v);
    in_format = v.fmt; in_imm = v.imm; in_opcode = v.opc; in_rd = v.rd;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7;
  endtask

  // Called at a falling edge; returns at a falling edge after acceptance.
  task automatic send(input vec_t v, input bit lat);
    exp_t e;
    bit acc;
    acc = 1'b0;
    drive(v);
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      #4;
      acc = in_ready;
      e.acc_cyc = cyc;
      @(posedge clk);
      if (acc) begin
        e.instr = v.instr; e.err = v.err; e.chk_lat = lat;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic sample_count();
    #4;
    chk("enc_count", {16'd0, enc_count}, {16'd0, exp_count});
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, accepts, idx;
    bit acc;
    exp_t e;

    vecs[0]  = mk(3'b000, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00093, 1'b0);
    vecs[1]  = mk(3'b010, 32'hFFFFFFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFE000EE3, 1'b0);
    vecs[2]  = mk(3'b100, 32'h00000008, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0080006F, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
    vecs[3]  = mk(3'b000, 32'h00000800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1);
    vecs[7]  = mk(3'b011, 32'h12345678, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1);
    vecs[8]  = mk(3'b010, 32'h00000003, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1);
`else
    vecs[3]  = mk(3'b000, 32'h00000800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h80000093, 1'b0);
    vecs[7]  = mk(3'b011, 32'h12345678, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h123451B7, 1'b0);
    vecs[8]  = mk(3'b010, 32'h00000003, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000163, 1'b0);
`endif
    vecs[4]  = mk(3'b110, 32'h12345678, 7'h13, 5'd7, 5'd8, 5'd9, 3'd5, 7'h00, 32'h00000000, 1'b1);
    vecs[5]  = mk(3'b001, 32'h00000025, 7'h23, 5'd0, 5'd6, 5'd5, 3'd2, 7'h00, 32'h025322A3, 1'b0);
    vecs[6]  = mk(3'b011, 32'h12345000, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h123451B7, 1'b0);
    vecs[9]  = mk(3'b100, 32'hFFFFFFFE, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF0EF, 1'b0);
    vecs[10] = mk(3'b101, 32'h00000004, 7'h6F, 5'd1, 5'd2, 5'd3, 3'd1, 7'h00, 32'h00000000, 1'b1);
    vecs[11] = mk(3'b000, 32'h00000005, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'h7F, 32'h00510113, 1'b0);
    vecs[12] = mk(3'b000, 32'hFFFFF800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h80000093, 1'b0);
    vecs[13] = mk(3'b111, 32'hFFFFFFFF, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000000, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_out_err", {31'd0, out_err}, 32'd0);
    chk("reset_enc_count", {16'd0, enc_count}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Back-to-back stream with out_ready high: latency 2, one accept per cycle.
    c0 = cyc;
    for (int i = 0; i < NVEC; i++) send(vecs[i], 1'b1);
    chk("throughput_cycles", cyc - c0, NVEC);
    drain();
    sample_count();

    // Backpressure: out_ready low for 4 cycles of continuous in_valid.
    out_ready = 1'b0;
    accepts = 0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive(vecs[idx]);
      in_valid = 1'b1;
      #4;
      acc = in_ready;
      e.acc_cyc = cyc;
      @(posedge clk);
      if (acc) begin
        e.instr = vecs[idx].instr; e.err = vecs[idx].err; e.chk_lat = 1'b0;
        sb.push_back(e);
        idx++;
        accepts++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_accepts", accepts, 32'd2);
    #4;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(vecs[idx + i], 1'b0);
    drain();
    sample_count();

    // Reset with two words in flight: they must be discarded.
    out_ready = 1'b0;
    send(vecs[5], 1'b0);
    send(vecs[6], 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 16'd0;
    #4;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_enc_count", {16'd0, enc_count}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    send(vecs[13], 1'b1);
    send(vecs[2], 1'b1);
    drain();
    sample_count();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
